// File: rtl/song_sequencer_if.sv
// song_sequencer_if: transport command, ROM and status bundle for the song sequencer.
//   slave  : the sequencer (takes commands and ROM data, drives ROM address/select and status)
//   master : the controlling side (buttons/ROM wrapper/testbench)
//   cmd_play/cmd_pause/cmd_stop : one-cycle command pulses
//   loop, song_sel              : level controls
//   rom_data / rom_addr/song_id : registered song ROM access
//   note, playing, paused, done : tone datapath feed and status
interface song_sequencer_if;
   logic       cmd_play;
   logic       cmd_pause;
   logic       cmd_stop;
   logic       loop;
   logic       song_sel;
   logic [7:0] rom_data;
   logic [7:0] rom_addr;
   logic       song_id;
   logic [7:0] note;
   logic       playing;
   logic       paused;
   logic       done;

   modport master (
      output cmd_play, cmd_pause, cmd_stop, loop, song_sel, rom_data,
      input  rom_addr, song_id, note, playing, paused, done
   );

   modport slave (
      input  cmd_play, cmd_pause, cmd_stop, loop, song_sel, rom_data,
      output rom_addr, song_id, note, playing, paused, done
   );
endinterface

// File: rtl/song_sequencer.sv
// song_sequencer: steps a song-ROM pointer at a fixed tempo with play/pause/stop/loop
// transport, selects one of two songs, and blanks the tail of a step when the next
// note is identical so repeated notes re-articulate.
//   CLK100MHZ : clock
//   rst       : asynchronous active-high reset
//   bus       : song_sequencer_if.slave (commands, ROM port, note and status)
module song_sequencer #(
   parameter int TICKS_PER_STEP = 8388608,
   parameter int GAP_TICKS      = 1048576,
   parameter int SONG0_LEN      = 196,
   parameter int SONG1_LEN      = 243,
   parameter int CNT_W          = 24
) (
   input  logic             CLK100MHZ,
   input  logic             rst,
   song_sequencer_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, FETCH1, FETCH2, PLAY, PAUSED} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICKS_PER_STEP - 1);
   localparam logic [CNT_W-1:0] GAP_START = CNT_W'(TICKS_PER_STEP - GAP_TICKS);
   localparam logic [7:0]       LAST0     = 8'(SONG0_LEN - 1);
   localparam logic [7:0]       LAST1     = 8'(SONG1_LEN - 1);
   localparam bit               GAP_EN    = (GAP_TICKS > 0);

   state_t           state, state_n;
   logic [7:0]       addr, addr_n;
   logic [7:0]       rom_addr_q, rom_addr_n;
   logic             song_id_q, song_id_n;
   logic [CNT_W-1:0] step_cnt, step_cnt_n;
   logic [7:0]       cur_note, cur_note_n;
   logic [7:0]       nxt_note, nxt_note_n;
   logic             done_q, done_n;
   logic             playing_q, paused_q;
   logic             last;
   logic             gap;
   logic [7:0]       note_c;

   assign last = (addr == (song_id_q ? LAST1 : LAST0));

   // Blank the end of a step only when the following note repeats this one;
   // the last step never blanks since its successor is not part of the song.
   assign gap = GAP_EN && (step_cnt >= GAP_START) && (nxt_note == cur_note) && !last;

   always_ff @(posedge CLK100MHZ or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         addr       <= '0;
         rom_addr_q <= '0;
         song_id_q  <= 1'b0;
         step_cnt   <= '0;
         cur_note   <= '0;
         nxt_note   <= '0;
         done_q     <= 1'b0;
         playing_q  <= 1'b0;
         paused_q   <= 1'b0;
      end else begin
         state      <= state_n;
         addr       <= addr_n;
         rom_addr_q <= rom_addr_n;
         song_id_q  <= song_id_n;
         step_cnt   <= step_cnt_n;
         cur_note   <= cur_note_n;
         nxt_note   <= nxt_note_n;
         done_q     <= done_n;
         // status flags are registered from the next state so they line up with it
         playing_q  <= (state_n == FETCH1) || (state_n == FETCH2) || (state_n == PLAY);
         paused_q   <= (state_n == PAUSED);
      end
   end

   always_comb begin
      state_n    = state;
      addr_n     = addr;
      rom_addr_n = rom_addr_q;
      song_id_n  = song_id_q;
      step_cnt_n = step_cnt;
      cur_note_n = cur_note;
      nxt_note_n = nxt_note;
      done_n     = 1'b0;

      if (bus.cmd_stop) begin
         state_n    = IDLE;
         addr_n     = '0;
         rom_addr_n = '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_play) begin
                  song_id_n  = bus.song_sel;
                  addr_n     = '0;
                  rom_addr_n = '0;
                  cur_note_n = '0;
                  state_n    = FETCH1;
               end
            end
            FETCH1: state_n = FETCH2;
            FETCH2: begin
               cur_note_n = bus.rom_data;
               rom_addr_n = addr + 8'd1;
               step_cnt_n = '0;
               state_n    = PLAY;
            end
            PLAY: begin
               step_cnt_n = step_cnt + CNT_ONE;
               // rom_addr already points at addr+1, so data is valid from count 1
               if (step_cnt == CNT_ONE)
                  nxt_note_n = bus.rom_data;
               if (step_cnt == CNT_LAST) begin
                  if (!last) begin
                     addr_n     = addr + 8'd1;
                     cur_note_n = nxt_note;
                     rom_addr_n = addr + 8'd2;
                     step_cnt_n = '0;
                  end else if (bus.loop) begin
                     addr_n     = '0;
                     rom_addr_n = '0;
                     state_n    = FETCH1;
                  end else begin
                     addr_n     = '0;
                     rom_addr_n = '0;
                     done_n     = 1'b1;
                     state_n    = IDLE;
                  end
               end
               // The pause cycle still counts as an active cycle; play outranks pause.
               if (bus.cmd_pause && !bus.cmd_play && state_n == PLAY)
                  state_n = PAUSED;
            end
            PAUSED: begin
               if (bus.cmd_play)
                  state_n = PLAY;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_comb begin
      note_c = '0;
      case (state)
         PLAY:           note_c = gap ? 8'd0 : cur_note;
         FETCH1, FETCH2: note_c = cur_note;
         default:        note_c = '0;
      endcase
   end

   assign bus.note     = note_c;
   assign bus.rom_addr = rom_addr_q;
   assign bus.song_id  = song_id_q;
   assign bus.playing  = playing_q;
   assign bus.paused   = paused_q;
   assign bus.done     = done_q;
endmodule

// File: doc/song_sequencer.md
# song_sequencer

Transport controller for the tone generator. It replaces the free-running tone counter as the song-ROM address source, and steps a ROM pointer at a fixed tempo. It provides play, pause, stop and loop control, selects one of two songs, and inserts a short rest between repeated identical notes so they re-articulate. Its `note` output feeds the divide-by-12 / clock-divider datapath directly, where 0 means silence.

## Interface
- `TICKS_PER_STEP`, 8388608: clock cycles per ROM step (2^23 ≈ 84 ms at 100 MHz); must be ≥ 4.
- `GAP_TICKS`, 1048576: silent cycles at the end of a step when the next note is identical; must be < `TICKS_PER_STEP - 2`.
- `SONG0_LEN`, 196: number of steps in song 0; must be ≥ 1 and ≤ 256.
- `SONG1_LEN`, 243: number of steps in song 1; must be ≥ 1 and ≤ 256.
- `CNT_W`, 24: step counter width; must hold `TICKS_PER_STEP - 1`.

Ports:
- `CLK100MHZ` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_play` in 1: one-cycle pulse; start from IDLE, or resume from PAUSED.
- `cmd_pause` in 1: one-cycle pulse; pause while in PLAY.
- `cmd_stop` in 1: one-cycle pulse; return to IDLE from any state.
- `loop` in 1: level; restart the song at its end instead of stopping.
- `song_sel` in 1: song choice, sampled only on a start.
- `rom_data` in 8: ROM note, valid one cycle after `rom_addr` (registered ROM).
- `rom_addr` out 8: ROM step address (registered).
- `song_id` out 1: latched song, used as the ROM mux select.
- `note` out 8: note to the tone datapath (0 = rest).
- `playing` out 1: high in FETCH1, FETCH2 and PLAY.
- `paused` out 1: high in PAUSED.
- `done` out 1: one-cycle pulse when a non-looping song ends.

## Operation
- States: IDLE, FETCH1, FETCH2, PLAY, PAUSED.
- Internal registers: `addr` (8 b), `step_cnt` (`CNT_W`), `cur_note`, `nxt_note`.
- `len = song_id ? SONG1_LEN : SONG0_LEN`; `last = (addr == len-1)`.
- **IDLE**
  - `note` = 0.
  - On `cmd_play`: `song_id <= song_sel`, `addr <= 0`, `rom_addr <= 0`, `cur_note <= 0`, go to FETCH1.
- **FETCH1**
  - Wait one cycle for the ROM to sample the address, then go to FETCH2.
- **FETCH2**
  - `cur_note <= rom_data`, `rom_addr <= addr+1`, `step_cnt <= 0`, go to PLAY.
- **PLAY**
  - `step_cnt` increments every cycle.
  - When `step_cnt == 1`: `nxt_note <= rom_data`. This prefetches step `addr+1`.
  - When `step_cnt == TICKS_PER_STEP-1`:
    - If not last: `addr <= addr+1`, `cur_note <= nxt_note`, `rom_addr <= addr+2` (8-bit wrap allowed; the value is unused past `len`), `step_cnt <= 0`.
    - If last and `loop`=1: `addr <= 0`, `rom_addr <= 0`, go to FETCH1. `cur_note` holds through the fetch.
    - If last and `loop`=0: pulse `done`, go to IDLE.
- **PAUSED**
  - `step_cnt`, `addr`, `rom_addr`, `cur_note` and `nxt_note` are frozen; `note` = 0.
  - `cmd_play` returns to PLAY and counting continues from the frozen count.
- **`note` output**
  - PLAY: `cur_note`, except it is 0 when all of these hold: `GAP_TICKS > 0`, `step_cnt ≥ TICKS_PER_STEP-GAP_TICKS`, `nxt_note == cur_note`, and not last.
  - FETCH1/FETCH2: `cur_note`. This is 0 on a fresh start and the held note on a loop restart.
  - IDLE and PAUSED: 0.
- **Command priority** (simultaneous commands): `cmd_stop` > `cmd_play` > `cmd_pause`.
- **Ignored commands**
  - `cmd_play` in PLAY/FETCH: no restart.
  - `cmd_pause` outside PLAY.
  - `song_sel` changes outside the IDLE start.
  - `loop` is sampled only at the last-step boundary.
- **Stop**: any state → IDLE. `rom_addr <= 0`, `addr <= 0`, `note` = 0 next cycle, `done` not pulsed.

## Timing
- **Reset values**: state IDLE, `rom_addr` 0, `song_id` 0, `note` 0, `playing` 0, `paused` 0, `done` 0. All internal counters and notes are 0.
- **Reset mid-song**: outputs take their reset values immediately (asynchronous). Operation resumes at the first clock edge after `rst` falls.
- **Start latency**: `cmd_play` at edge E → FETCH1 at E+1 → FETCH2 at E+2 → PLAY with `note = rom[0]` from E+3.
- **Step length**: exactly `TICKS_PER_STEP` cycles. Loop restart adds 2 cycles of held note.
- **Outputs**: all registered, except `note`, which is a combinational function of registers only (no input paths).
- **`done`**: high for exactly one cycle, concurrent with the entry to IDLE.

## Test plan
Common setup: `TICKS_PER_STEP`=8, `GAP_TICKS`=2, `SONG0_LEN`=4, `SONG1_LEN`=3, behavioural registered ROM (song0 = 5,5,7,0; song1 = 9,10,11).

- **Basic play**: `cmd_play`, `song_sel`=0, `loop`=0.
  - `note` = 5 for 6 cycles, 0 for 2 cycles, 5 for 8, 7 for 8, then 0 for 8.
  - `done` pulses once; then IDLE with `rom_addr` 0.
- **Loop**: `song_sel`=1, `loop`=1.
  - Sequence 9,10,11, then 11 held 2 more cycles, then 9…
  - `done` never asserts.
  - `song_sel` toggled mid-song has no effect.
- **Pause/resume**: `cmd_pause` at `step_cnt`=3 of step 1.
  - `note` = 0 and `paused` = 1 for 20 cycles.
  - After `cmd_play`, step 1 finishes in 4 more cycles; total active cycles are unchanged.
- **Stop mid-step**: `cmd_stop` in PLAY, and again in FETCH2.
  - IDLE next cycle, `note` 0, no `done`.
  - A subsequent `cmd_play` starts again at `rom[0]`.
- **Simultaneous commands**: `cmd_play`+`cmd_stop` in IDLE gives IDLE; `cmd_pause`+`cmd_play` in PLAY stays in PLAY.
- **Async reset**: assert `rst` mid-PLAY between clock edges; all outputs go to 0 before the next edge.
